cmd_parser: RTL and testbench

CMD_PARSER -- requirements
Module: cmd_parser

---
 rtl/cmd_parser.sv | 118 +++++++++++
 tb/tb_cmd_parser.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_parser.sv
// Framed command decoder for the AVR serial link: A5 sync, cmd, len, payload, XOR checksum.
// Optional inter-byte timeout is compiled in when CMD_PARSER_TIMEOUT_EN is defined.
module cmd_parser #(
    parameter int MAX_LEN       = 8,
    parameter int TIMEOUT_TICKS = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_id,
    output logic [3:0]  cmd_len,
    output logic [63:0] cmd_payload,
    output logic        err,
    output logic [1:0]  err_code
);
    typedef enum logic [2:0] {SYNC, CMD, LEN, PAYLOAD, CHK} state_t;

    state_t      state;
    logic [7:0]  id_r;
    logic [7:0]  chk_r;
    logic [3:0]  len_r;
    logic [3:0]  idx;
    logic [63:0] pay_r;

`ifdef CMD_PARSER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_TICKS + 1);
    logic [CW-1:0] tcnt;
    logic          expire;
    // Expiry is the tick that would bring the count up to TIMEOUT_TICKS.
    assign expire = tick && (state != SYNC) && (tcnt == CW'(TIMEOUT_TICKS - 1));
`else
    logic tick_unused;
    assign tick_unused = tick;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SYNC;
            id_r        <= '0;
            chk_r       <= '0;
            len_r       <= '0;
            idx         <= '0;
            pay_r       <= '0;
            cmd_valid   <= 1'b0;
            cmd_id      <= '0;
            cmd_len     <= '0;
            cmd_payload <= '0;
            err         <= 1'b0;
            err_code    <= '0;
`ifdef CMD_PARSER_TIMEOUT_EN
            tcnt        <= '0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            err       <= 1'b0;
`ifdef CMD_PARSER_TIMEOUT_EN
            if (state == SYNC || new_rx_data)
                tcnt <= '0;
            else if (tick)
                tcnt <= tcnt + 1'b1;
`endif
            if (new_rx_data) begin
                case (state)
                    SYNC: if (rx_data == 8'hA5) state <= CMD;
                    CMD: begin
                        id_r  <= rx_data;
                        chk_r <= rx_data;
                        state <= LEN;
                    end
                    LEN: begin
                        len_r <= rx_data[3:0];
                        chk_r <= chk_r ^ rx_data;
                        pay_r <= '0;
                        idx   <= '0;
                        if (rx_data > 8'(MAX_LEN)) begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                            state    <= SYNC;
                        end else if (rx_data == 8'd0) begin
                            state <= CHK;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        pay_r[{idx[2:0], 3'b000} +: 8] <= rx_data;
                        chk_r <= chk_r ^ rx_data;
                        idx   <= idx + 4'd1;
                        if (idx + 4'd1 == len_r) state <= CHK;
                    end
                    CHK: begin
                        if (rx_data == chk_r) begin
                            cmd_valid   <= 1'b1;
                            cmd_id      <= id_r;
                            cmd_len     <= len_r;
                            cmd_payload <= pay_r;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'd1;
                        end
                        state <= SYNC;
                    end
                    default: state <= SYNC;
                endcase
            end
`ifdef CMD_PARSER_TIMEOUT_EN
            else if (expire) begin
                err      <= 1'b1;
                err_code <= 2'd3;
                state    <= SYNC;
            end
`endif
        end
    end
endmodule

// File: tb/tb_cmd_parser.sv
// Bench for cmd_parser: frame-level queue model compared against the DUT every cycle.
module tb_cmd_parser;
    localparam int MAX_LEN = 8;
    localparam int TO      = 50;

    logic        clk = 1'b0;
    logic        rst, tick, new_rx_data;
    logic [7:0]  rx_data;
    logic        cmd_valid, err;
    logic [7:0]  cmd_id;
    logic [3:0]  cmd_len;
    logic [63:0] cmd_payload;
    logic [1:0]  err_code;

    cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_TICKS(TO)) dut (
        .clk(clk), .rst(rst), .tick(tick), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_len(cmd_len), .cmd_payload(cmd_payload),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bytes collected since the sync byte; a frame is judged once complete.
    logic [7:0]  frame[$];
    logic [7:0]  stim[$];
    int          tcount;
    logic        e_valid, e_err;
    logic [1:0]  e_code;
    logic [7:0]  e_id;
    logic [3:0]  e_len;
    logic [63:0] e_pay;

    function automatic logic [79:0] obs();
        return {cmd_valid, err, err_code, cmd_id, cmd_len, cmd_payload};
    endfunction

    function automatic logic [79:0] expv();
        return {e_valid, e_err, e_code, e_id, e_len, e_pay};
    endfunction

    task automatic model_reset();
        frame.delete();
        tcount = 0;
        e_valid = 0; e_err = 0; e_code = 0; e_id = 0; e_len = 0; e_pay = 0;
    endtask

    task automatic model_step(input logic s, input logic [7:0] b, input logic tk);
        e_valid = 0;
        e_err   = 0;
        if (s) begin
            tcount = 0;
            if (frame.size() == 0) begin
                if (b == 8'hA5) frame.push_back(b);
            end else begin
                frame.push_back(b);
                if (frame.size() == 3 && int'(frame[2]) > MAX_LEN) begin
                    e_err = 1; e_code = 2; frame.delete();
                end else if (frame.size() >= 3 && frame.size() == int'(frame[2]) + 4) begin
                    logic [7:0] x;
                    x = 0;
                    for (int i = 1; i < frame.size() - 1; i++) x ^= frame[i];
                    if (x == frame[frame.size()-1]) begin
                        e_valid = 1;
                        e_id    = frame[1];
                        e_len   = frame[2][3:0];
                        e_pay   = 0;
                        for (int i = 0; i < int'(frame[2]); i++) e_pay[8*i +: 8] = frame[3+i];
                    end else begin
                        e_err = 1; e_code = 1;
                    end
                    frame.delete();
                end
            end
        end else if (tk && frame.size() != 0) begin
            tcount++;
`ifdef CMD_PARSER_TIMEOUT_EN
            if (tcount == TO) begin
                e_err = 1; e_code = 3; frame.delete(); tcount = 0;
            end
`endif
        end
    endtask

    // One clock cycle: drive at negedge, DUT reacts on posedge, outputs sampled at next negedge.
    task automatic step(input logic s, input logic [7:0] b, input logic tk);
        new_rx_data = s; rx_data = b; tick = tk;
        @(negedge clk);
        model_step(s, b, tk);
        new_rx_data = 0; tick = 0;
    endtask

    task automatic test_reset();
        rst = 1; new_rx_data = 0; tick = 0; rx_data = 0;
        model_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs() !== 80'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", obs());
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        stim = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        for (int i = 0; i < stim.size(); i++) begin
            step(1, stim[i], 0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL good_frame b%0d: got %h want %h", i, obs(), expv());
            end
        end
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd_id !== 8'h10 || cmd_len !== 4'd2 || cmd_payload !== 64'h2211) begin
            n_fail++; $display("FAIL good_frame_fields: got v=%b id=%h len=%0d pay=%h want v=1 id=10 len=2 pay=2211",
                cmd_valid, cmd_id, cmd_len, cmd_payload);
        end
        step(0, 8'h00, 0);
        n_tests++;
        if (cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL good_frame_pulse: got cmd_valid=%b want 0", cmd_valid);
        end
    endtask

    task automatic test_junk_zero_len();
        stim = '{8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'h07};
        for (int i = 0; i < stim.size(); i++) begin
            step(1, stim[i], 0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL junk_zero_len b%0d: got %h want %h", i, obs(), expv());
            end
        end
        n_tests++;
        if (cmd_valid !== 1'b1 || cmd_id !== 8'h07 || cmd_len !== 4'd0 || cmd_payload !== 64'h0) begin
            n_fail++; $display("FAIL zero_len_fields: got v=%b id=%h len=%0d pay=%h want v=1 id=07 len=0 pay=0",
                cmd_valid, cmd_id, cmd_len, cmd_payload);
        end
    endtask

    task automatic test_bad_chk();
        stim = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20, 8'hA5, 8'h33, 8'h01, 8'hA5, 8'h97};
        for (int i = 0; i < stim.size(); i++) begin
            step(1, stim[i], 0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL bad_chk b%0d: got %h want %h", i, obs(), expv());
            end
            if (i == 5) begin
                n_tests++;
                if (err !== 1'b1 || err_code !== 2'd1 || cmd_valid !== 1'b0) begin
                    n_fail++; $display("FAIL bad_chk_err: got err=%b code=%0d v=%b want err=1 code=1 v=0",
                        err, err_code, cmd_valid);
                end
            end
        end
    endtask

    task automatic test_bad_len();
        stim = '{8'hA5, 8'h10, 8'h09, 8'h10, 8'hA5, 8'h44, 8'h08,
                 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h44};
        for (int i = 0; i < stim.size(); i++) begin
            step(1, stim[i], 0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL bad_len b%0d: got %h want %h", i, obs(), expv());
            end
            if (i == 2) begin
                n_tests++;
                if (err !== 1'b1 || err_code !== 2'd2) begin
                    n_fail++; $display("FAIL bad_len_err: got err=%b code=%0d want err=1 code=2", err, err_code);
                end
            end
        end
    endtask

    task automatic test_rst_midframe();
        stim = '{8'hA5, 8'h10, 8'h02, 8'h11};
        for (int i = 0; i < stim.size(); i++) step(1, stim[i], 0);
        rst = 1;
        @(negedge clk);
        model_reset();
        n_tests++;
        if (obs() !== 80'h0) begin
            n_fail++; $display("FAIL rst_midframe: got %h want 0", obs());
        end
        rst = 0;
        stim = '{8'h22, 8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        for (int i = 0; i < stim.size(); i++) begin
            step(1, stim[i], 0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL rst_recover b%0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_timeout();
        step(1, 8'hA5, 0);
        step(1, 8'h10, 0);
        for (int i = 0; i < TO + 10; i++) begin
            step(0, 8'h00, 1);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL timeout t%0d: got %h want %h", i, obs(), expv());
            end
            if (e_err) break;
        end
`ifdef CMD_PARSER_TIMEOUT_EN
        n_tests++;
        if (err !== 1'b1 || err_code !== 2'd3) begin
            n_fail++; $display("FAIL timeout_err: got err=%b code=%0d want err=1 code=3", err, err_code);
        end
        step(1, 8'hA5, 0);
        step(1, 8'h10, 0);
        for (int i = 0; i < TO - 1; i++) step(0, 8'h00, 1);
        step(1, 8'h02, 1);
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_priority: got err=%b want 0", err);
        end
`endif
        stim = '{8'h02, 8'h11, 8'h22, 8'h21};
        if (frame.size() == 0) stim = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        if (frame.size() == 3) stim = '{8'h11, 8'h22, 8'h21};
        for (int i = 0; i < stim.size(); i++) begin
            step(1, stim[i], 0);
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL timeout_recover b%0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_random(input int frames, input int max_gap);
        for (int f = 0; f < frames; f++) begin
            int kind, len;
            logic [7:0] x;
            stim.delete();
            kind = $urandom_range(0, 9);
            len  = $urandom_range(0, MAX_LEN);
            if (kind == 9) begin
                stim.push_back(8'($urandom_range(0, 255)));
            end else begin
                stim.push_back(8'hA5);
                stim.push_back(8'($urandom));
                if (kind == 8) len = $urandom_range(MAX_LEN + 1, 255);
                stim.push_back(8'(len));
                x = stim[1] ^ stim[2];
                if (kind != 8) begin
                    for (int i = 0; i < len; i++) begin
                        stim.push_back(8'($urandom));
                        x ^= stim[stim.size()-1];
                    end
                    stim.push_back(kind == 7 ? x ^ 8'($urandom_range(1, 255)) : x);
                end
            end
            for (int i = 0; i < stim.size(); i++) begin
                int gap;
                gap = $urandom_range(0, max_gap);
                for (int g = 0; g < gap; g++) begin
                    step(0, 8'($urandom), ($urandom_range(0, 3) == 0));
                    n_tests++;
                    if (obs() !== expv()) begin
                        n_fail++; $display("FAIL random f%0d idle: got %h want %h", f, obs(), expv());
                    end
                end
                step(1, stim[i], ($urandom_range(0, 3) == 0));
                n_tests++;
                if (obs() !== expv()) begin
                    n_fail++; $display("FAIL random f%0d b%0d: got %h want %h", f, i, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        rst = 1; tick = 0; new_rx_data = 0; rx_data = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_junk_zero_len();
        test_bad_chk();
        test_bad_len();
        test_rst_midframe();
        test_timeout();
        test_random(60, 0);
        test_random(60, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
